// File: rtl/pbus_pkg.sv
// Shared PBus definitions: request encodings, initiator state, responder window sizes.
package pbus_pkg;

    localparam logic [1:0] PBREQ_IDLE = 2'b00;
    localparam logic [1:0] PBREQ_RD   = 2'b01;
    localparam logic [1:0] PBREQ_WR   = 2'b10;

    localparam int unsigned IROM_WORDS = 1024;
    localparam int unsigned IRAM_WORDS = 2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } pbus_state_e;

endpackage

// File: rtl/pbus_decode.sv
// Combinational PBus address decode: maps a word address onto the IRAM/IROM windows.
module pbus_decode
    import pbus_pkg::*;
#(
    parameter logic [15:0] IROM_BASE = 16'h0000,
    parameter logic [15:0] IRAM_BASE = 16'h1000
) (
    input  logic [14:0] addr,
    output logic        sel_iram,
    output logic        sel_irom,
    output logic        unmapped
);

    localparam logic [16:0] IROM_LO    = {1'b0, IROM_BASE};
    localparam logic [16:0] IRAM_LO    = {1'b0, IRAM_BASE};
    localparam logic [16:0] IROM_BYTES = 17'(2 * IROM_WORDS);
    localparam logic [16:0] IRAM_BYTES = 17'(2 * IRAM_WORDS);

    logic [16:0] byte_addr;
    logic [16:0] irom_off;
    logic [16:0] iram_off;

    // Offsets are taken in 17 bits so an address below a base wraps far above any window size.
    always_comb begin
        byte_addr = {1'b0, addr, 1'b0};
        irom_off  = byte_addr - IROM_LO;
        iram_off  = byte_addr - IRAM_LO;
        sel_irom  = irom_off < IROM_BYTES;
        sel_iram  = iram_off < IRAM_BYTES;
        unmapped  = !sel_irom && !sel_iram;
    end

endmodule

// File: rtl/pbus_initiator.sv
// PBus master: accepts one core request, decodes it, runs one bus cycle with timeout and returns a response.
module pbus_initiator
    import pbus_pkg::*;
#(
    parameter logic [15:0] IROM_BASE = 16'h0000,
    parameter logic [15:0] IRAM_BASE = 16'h1000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_be,
    output logic        cpu_rsp_valid,
    output logic [15:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,
    output logic [14:0] PBusAddr,
    output logic [15:0] PBusData,
    output logic [1:0]  PBusBE,
    output logic [1:0]  PBusReqToIRAM,
    output logic [1:0]  PBusReqToIROM,
    input  logic [15:0] PBusDataIRAM,
    input  logic [15:0] PBusDataIROM,
    input  logic        PBusRdyIRAM,
    input  logic        PBusRdyIROM
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    pbus_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        tgt_iram_q, tgt_iram_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  be_q, be_d;
    logic [1:0]  req_iram_q, req_iram_d;
    logic [1:0]  req_irom_q, req_irom_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;

    logic        sel_iram, sel_irom, unmapped;
    logic        tgt_rdy;
    logic [15:0] tgt_data;

    pbus_decode #(
        .IROM_BASE(IROM_BASE),
        .IRAM_BASE(IRAM_BASE)
    ) u_decode (
        .addr    (cpu_addr),
        .sel_iram(sel_iram),
        .sel_irom(sel_irom),
        .unmapped(unmapped)
    );

    assign tgt_rdy  = tgt_iram_q ? PBusRdyIRAM  : PBusRdyIROM;
    assign tgt_data = tgt_iram_q ? PBusDataIRAM : PBusDataIROM;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        tgt_iram_d  = tgt_iram_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        req_iram_d  = req_iram_q;
        req_irom_d  = req_irom_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    we_d   = cpu_we;
                    addr_d = cpu_addr;
                    data_d = cpu_wdata;
                    be_d   = cpu_be;
                    cnt_d  = '0;
                    // IROM is read-only, so a store there fails without touching the bus.
                    if ((sel_irom && cpu_we) || unmapped) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_BUS;
                        tgt_iram_d = sel_iram;
                        if (sel_iram) req_iram_d = cpu_we ? PBREQ_WR : PBREQ_RD;
                        else          req_irom_d = PBREQ_RD;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (tgt_rdy) begin
                    state_d     = ST_RESP;
                    req_iram_d  = PBREQ_IDLE;
                    req_irom_d  = PBREQ_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 16'h0000 : tgt_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    req_iram_d  = PBREQ_IDLE;
                    req_irom_d  = PBREQ_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            tgt_iram_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            req_iram_q  <= PBREQ_IDLE;
            req_irom_q  <= PBREQ_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            tgt_iram_q  <= tgt_iram_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            req_iram_q  <= req_iram_d;
            req_irom_q  <= req_irom_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cpu_req_ready = (state_q == ST_IDLE);
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_err   = rsp_err_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign PBusAddr      = addr_q;
    assign PBusData      = data_q;
    assign PBusBE        = be_q;
    assign PBusReqToIRAM = req_iram_q;
    assign PBusReqToIROM = req_irom_q;

endmodule

// File: tb/tb_pbus_initiator.sv
// Randomized bench for pbus_initiator: stub IRAM/IROM responders plus a transaction-level reference model.
module tb_pbus_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid, cpu_req_ready, cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_rsp_valid, cpu_rsp_err;
    logic [15:0] cpu_rsp_rdata;
    logic [14:0] PBusAddr;
    logic [15:0] PBusData;
    logic [1:0]  PBusBE, PBusReqToIRAM, PBusReqToIROM;
    logic [15:0] PBusDataIRAM, PBusDataIROM;
    logic        PBusRdyIRAM, PBusRdyIROM;

    pbus_initiator #(
        .IROM_BASE(16'h0000),
        .IRAM_BASE(16'h1000),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_be       (cpu_be),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_err  (cpu_rsp_err),
        .PBusAddr     (PBusAddr),
        .PBusData     (PBusData),
        .PBusBE       (PBusBE),
        .PBusReqToIRAM(PBusReqToIRAM),
        .PBusReqToIROM(PBusReqToIROM),
        .PBusDataIRAM (PBusDataIRAM),
        .PBusDataIROM (PBusDataIROM),
        .PBusRdyIRAM  (PBusRdyIRAM),
        .PBusRdyIROM  (PBusRdyIROM)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder-side storage (written only through the bus) and the model's view of it.
    logic [15:0] ram_mem [2048];
    logic [15:0] rom_mem [1024];
    logic [15:0] mdl_ram [2048];
    logic [15:0] mdl_rom [1024];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // Each target answers only its own request, d cycles after it first appears; idle targets emit noise.
    task automatic drive_rdy(input int k, input int d);
        if (PBusReqToIRAM != 2'b00) begin
            PBusRdyIRAM  = (k - 1 == d);
            PBusDataIRAM = (PBusAddr >= 15'h0800 && PBusAddr < 15'h1000) ? ram_mem[PBusAddr[10:0]] : 16'($urandom);
        end else begin
            PBusRdyIRAM  = 1'($urandom);
            PBusDataIRAM = 16'($urandom);
        end
        if (PBusReqToIROM != 2'b00) begin
            PBusRdyIROM  = (k - 1 == d);
            PBusDataIROM = (PBusAddr < 15'h0400) ? rom_mem[PBusAddr[9:0]] : 16'($urandom);
        end else begin
            PBusRdyIROM  = 1'($urandom);
            PBusDataIROM = 16'($urandom);
        end
    endtask

    task automatic do_req(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, input int d);
        logic [15:0] byte_a;
        logic        irom, iram, exp_err, got_err;
        logic [1:0]  exp_code;
        logic [15:0] exp_rd, got_rd;
        int          exp_k, exp_rc, rsp_k, rc, bad_req, bad_bus, w;

        byte_a   = {addr, 1'b0};
        irom     = byte_a < 16'h0800;
        iram     = byte_a >= 16'h1000 && byte_a < 16'h2000;
        exp_code = we ? 2'b10 : 2'b01;
        exp_rd   = 16'h0000;
        if ((irom && we) || !(irom || iram)) begin
            exp_err = 1'b1; exp_k = 1;      exp_rc = 0;
        end else if (d >= TO) begin
            exp_err = 1'b1; exp_k = TO + 1; exp_rc = TO;
        end else begin
            exp_err = 1'b0; exp_k = d + 2;  exp_rc = d + 1;
            if (iram) begin
                if (we) mdl_ram[addr[10:0]] = merge(mdl_ram[addr[10:0]], wd, be);
                else    exp_rd = mdl_ram[addr[10:0]];
            end else begin
                exp_rd = mdl_rom[addr[9:0]];
            end
        end

        w = 0;
        while (!cpu_req_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_req", cpu_req_ready, 1);

        cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0; cpu_we = 1'($urandom); cpu_addr = 15'($urandom);
        cpu_wdata = 16'($urandom); cpu_be = 2'($urandom);

        rsp_k = 0; rc = 0; bad_req = 0; bad_bus = 0; got_err = 1'b0; got_rd = 16'h0000;
        for (int k = 1; k <= TO + 4 && rsp_k == 0; k++) begin
            drive_rdy(k, d);
            @(negedge clk);
            if (PBusReqToIRAM != 2'b00 || PBusReqToIROM != 2'b00) begin
                rc++;
                if ((iram ? PBusReqToIRAM : PBusReqToIROM) != exp_code ||
                    (iram ? PBusReqToIROM : PBusReqToIRAM) != 2'b00) bad_req++;
                if (PBusAddr !== addr || PBusData !== wd || PBusBE !== be) bad_bus++;
            end
            if (PBusReqToIRAM == 2'b10 && PBusRdyIRAM)
                ram_mem[PBusAddr[10:0]] = merge(ram_mem[PBusAddr[10:0]], PBusData, PBusBE);
            if (cpu_rsp_valid) begin
                rsp_k = k; got_err = cpu_rsp_err; got_rd = cpu_rsp_rdata;
            end
            @(posedge clk); #1;
        end
        PBusRdyIRAM = 1'b0;
        PBusRdyIROM = 1'b0;

        chk("rsp_cycle", rsp_k, exp_k);
        chk("rsp_err", got_err, exp_err);
        chk("rsp_rdata", got_rd, exp_rd);
        chk("req_cycles", rc, exp_rc);
        chk("req_code_bad", bad_req, 0);
        chk("bus_fields_bad", bad_bus, 0);
        chk("ready_after_rsp", cpu_req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] bnd [7];
        logic [14:0] a;
        int          seen, r, d;

        bnd = '{15'h03FF, 15'h0400, 15'h07FF, 15'h0800, 15'h0FFF, 15'h1000, 15'h7FFF};
        for (int i = 0; i < 2048; i++) begin ram_mem[i] = 16'($urandom); mdl_ram[i] = ram_mem[i]; end
        for (int i = 0; i < 1024; i++) begin rom_mem[i] = 16'($urandom); mdl_rom[i] = rom_mem[i]; end

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        PBusRdyIRAM = 1'b0; PBusRdyIROM = 1'b0; PBusDataIRAM = '0; PBusDataIROM = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cpu_req_ready, 1);
        chk("rst_rsp_valid", cpu_rsp_valid, 0);
        chk("rst_rsp_err", cpu_rsp_err, 0);
        chk("rst_rsp_rdata", cpu_rsp_rdata, 0);
        chk("rst_req", {PBusReqToIRAM, PBusReqToIROM}, 0);
        chk("rst_addr", PBusAddr, 0);
        chk("rst_data", PBusData, 0);
        chk("rst_be", PBusBE, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IRAM load of a known word, byte-merge store/load, be=00 store, minimum latency
        ram_mem[2] = 16'hBEEF; mdl_ram[2] = 16'hBEEF;
        do_req(1'b0, 15'h0802, 16'h0000, 2'b11, 1);
        ram_mem[8] = 16'hFFFF; mdl_ram[8] = 16'hFFFF;
        do_req(1'b1, 15'h0808, 16'h12AB, 2'b01, 1);
        chk("byte_merge_mem", ram_mem[8], 16'hFFAB);
        do_req(1'b0, 15'h0808, 16'h5555, 2'b00, 1);
        do_req(1'b1, 15'h0808, 16'h0000, 2'b00, 0);
        do_req(1'b0, 15'h0808, 16'h0000, 2'b10, 0);

        // decode errors and IROM read
        do_req(1'b1, 15'h0004, 16'hAAAA, 2'b11, 1);
        do_req(1'b0, 15'h4000, 16'h0000, 2'b11, 1);
        do_req(1'b0, 15'h0000, 16'h0000, 2'b11, 1);

        // timeout, then a late ready while idle must be ignored
        do_req(1'b0, 15'h0900, 16'h0000, 2'b11, 1000);
        seen = 0;
        PBusRdyIRAM = 1'b1; PBusRdyIROM = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rsp_valid || PBusReqToIRAM != 2'b00 || PBusReqToIROM != 2'b00) seen++;
        end
        PBusRdyIRAM = 1'b0; PBusRdyIROM = 1'b0;
        chk("late_rdy_ignored", seen, 0);
        @(posedge clk); #1;

        // reset in the middle of a bus cycle drops the request and the response
        cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0810; cpu_be = 2'b11;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        chk("midrst_req_on", PBusReqToIRAM, 2'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_req_off", {PBusReqToIRAM, PBusReqToIROM}, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        @(posedge clk); #1;
        do_req(1'b0, 15'h0810, 16'h0000, 2'b11, 1);

        // random mix across windows, boundaries, delays and timeouts
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 15'($urandom_range(0, 1023));
                1, 2:    a = 15'($urandom_range(16'h0800, 16'h0FFF));
                3:       a = bnd[$urandom_range(0, 6)];
                4:       a = 15'($urandom);
                default: a = 15'($urandom_range(16'h0800, 16'h0807));
            endcase
            r = $urandom_range(0, 9);
            d = (r < 6) ? r % 3 : (r == 6) ? TO - 1 : (r == 7) ? TO : 1;
            do_req(1'($urandom), a, 16'($urandom), 2'($urandom), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
